// File: rtl/apb_ram_arbiter.sv
// apb_ram_arbiter
// Lets two APB3 requesters (CPU side and DMA side) share the single
// register/RAM slave port. Transfers are serialised with round-robin
// arbitration. Each transfer runs IDLE -> ISSUE -> RESP: the slave access
// happens in ISSUE, and the completion/read data is returned in RESP.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata/pstrbN : requester N APB inputs
//   preadyN/prdataN/pslverrN               : requester N APB responses
//   mem_enable/we/addr/din/pstrb           : slave request (valid in ISSUE)
//   mem_ready, mem_dout                    : slave handshake / registered read data
//   grant_id             : currently / last granted requester
//   busy                 : arbiter not idle
//
// Build option
//   APB_ARB_PSLVERR_EN : when defined, an address outside the mapped region
//                        (top two bits != 2'b00) never reaches the slave. It
//                        is answered with pslverr=1 and prdata=0. When the
//                        macro is undefined, pslverr is tied low and every
//                        access is forwarded.
module apb_ram_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel0,
    input  logic                    penable0,
    input  logic                    pwrite0,
    input  logic [ADDR_WIDTH-1:0]   paddr0,
    input  logic [WIDTH-1:0]        pwdata0,
    input  logic [WIDTH/8-1:0]      pstrb0,
    output logic                    pready0,
    output logic [WIDTH-1:0]        prdata0,
    output logic                    pslverr0,
    input  logic                    psel1,
    input  logic                    penable1,
    input  logic                    pwrite1,
    input  logic [ADDR_WIDTH-1:0]   paddr1,
    input  logic [WIDTH-1:0]        pwdata1,
    input  logic [WIDTH/8-1:0]      pstrb1,
    output logic                    pready1,
    output logic [WIDTH-1:0]        prdata1,
    output logic                    pslverr1,
    output logic                    mem_enable,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]        mem_din,
    output logic [WIDTH/8-1:0]      mem_pstrb,
    input  logic                    mem_ready,
    input  logic [WIDTH-1:0]        mem_dout,
    output logic                    grant_id,
    output logic                    busy
);
    localparam int SW = WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                  state, state_nxt;
    logic                    last_grant, grant_q;
    logic                    req_we;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [WIDTH-1:0]        req_din;
    logic [SW-1:0]           req_strb;
    logic                    req_err;

    logic                    take, take_id;
    logic [ADDR_WIDTH-1:0]   take_addr;
    logic                    take_err;
    logic                    g_sel, g_en;

    // Only the granted requester's handshake matters while busy.
    assign g_sel     = grant_q ? psel1    : psel0;
    assign g_en      = grant_q ? penable1 : penable0;
    assign take_addr = take_id ? paddr1   : paddr0;
`ifdef APB_ARB_PSLVERR_EN
    assign take_err  = (take_addr[ADDR_WIDTH-1 -: 2] != 2'b00);
`else
    assign take_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        // On a tie, the requester that was not served last wins.
        take_id   = (psel0 && psel1) ? ~last_grant : psel1;
        case (state)
            IDLE: begin
                if (psel0 || psel1) begin
                    take      = 1'b1;
                    state_nxt = take_err ? RESP : ISSUE;
                end
            end
            ISSUE: if (mem_ready) state_nxt = RESP;
            // A dropped psel abandons the transfer. The slave access is already done.
            RESP:  if (!g_sel || g_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_din    <= '0;
            req_strb   <= '0;
            req_err    <= 1'b0;
        end else if (take) begin
            last_grant <= take_id;
            grant_q    <= take_id;
            req_we     <= take_id ? pwrite1 : pwrite0;
            req_addr   <= take_addr;
            req_din    <= take_id ? pwdata1 : pwdata0;
            req_strb   <= take_id ? pstrb1  : pstrb0;
            req_err    <= take_err;
        end
    end

    logic             in_issue, in_resp;
    logic [WIDTH-1:0] rd_data;

    assign in_issue   = (state == ISSUE);
    assign in_resp    = (state == RESP);
    assign busy       = (state != IDLE);
    assign grant_id   = grant_q;

    assign mem_enable = in_issue;
    assign mem_we     = in_issue & req_we;
    assign mem_addr   = in_issue ? req_addr : '0;
    assign mem_din    = in_issue ? req_din  : '0;
    assign mem_pstrb  = in_issue ? req_strb : '0;

    // mem_dout is registered by the slave, so it is valid throughout RESP.
    assign rd_data    = (in_resp && !req_we && !req_err) ? mem_dout : '0;

    assign pready0    = in_resp & ~grant_q;
    assign pready1    = in_resp &  grant_q;
    assign prdata0    = grant_q ? '0 : rd_data;
    assign prdata1    = grant_q ? rd_data : '0;
    assign pslverr0   = in_resp & ~grant_q & req_err;
    assign pslverr1   = in_resp &  grant_q & req_err;
endmodule

// File: doc/apb_ram_arbiter.md
Name: apb_ram_arbiter

Overview:
- Two-requester APB arbiter that shares the single register/RAM slave port (enable/we/addr/din/pstrb/ready/dout) between two APB requesters.
- Each requester sees an APB3 completer interface. The block serialises their transfers with round-robin arbitration, sequences the slave access, and returns read data and completion.
- Sits between the two bus masters (CPU-side and DMA-side) and the register/RAM block.

Parameters:
- WIDTH, 32, data width; strobe width is WIDTH/8.
- ADDR_WIDTH, 16, address width; addr[ADDR_WIDTH-1:ADDR_WIDTH-2]==2'b00 is the mapped region.

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- psel0, penable0, pwrite0  input  1 each  requester 0 APB control
- paddr0  input  ADDR_WIDTH  requester 0 address
- pwdata0  input  WIDTH  requester 0 write data
- pstrb0  input  WIDTH/8  requester 0 byte strobes
- pready0  output  1  requester 0 completion
- prdata0  output  WIDTH  requester 0 read data
- pslverr0  output  1  requester 0 error
- psel1, penable1, pwrite1, paddr1, pwdata1, pstrb1, pready1, prdata1, pslverr1: same as requester 0, for requester 1
- mem_enable  output  1  slave enable
- mem_we  output  1  slave write enable
- mem_addr  output  ADDR_WIDTH  slave address
- mem_din  output  WIDTH  slave write data
- mem_pstrb  output  WIDTH/8  slave byte enables
- mem_ready  input  1  slave ready
- mem_dout  input  WIDTH  slave read data; registered, valid the cycle after an enabled read edge
- grant_id  output  1  currently/last granted requester
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (already decided): one clock; reset is synchronous and active-high.
- Reset values: all outputs 0; FSM=IDLE; last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any pselN=1, grant it and go to ISSUE.
  - If both pselN=1, grant the requester != last_grant.
  - On grant, latch paddr/pwdata/pstrb/pwrite into the request register, set grant_id and last_grant.
  - A new request is accepted at the same edge at which its psel is first sampled; penable is not required in IDLE.
- ISSUE:
  - mem_enable=1; mem_we/addr/din/pstrb driven from the request register.
  - Stay until mem_ready=1 is sampled, then go to RESP.
  - With the current slave, ISSUE is exactly 1 cycle.
- RESP:
  - mem_enable=0; granted pready=1; prdata=mem_dout for reads, 0 for writes.
  - pready is combinational from state; non-granted pready, prdata and pslverr stay 0.
  - Go to IDLE when granted psel&penable is sampled (handshake complete).
- Abandoned transfer: if the granted psel is low in RESP, return to IDLE without a handshake. A slave access already issued is not undone.
- Latency: minimum 3 cycles from psel sampled to pready sampled (IDLE, ISSUE, RESP).
- Back-to-back: return to IDLE costs one cycle. A waiting requester is granted next by round robin, so no starvation.
- The non-granted requester's signals are ignored until IDLE. Requesters hold their signals stable until pready, per APB.
- Reset mid-operation: rst=1 in any state forces IDLE with mem_enable=0 and all pready=0 on the next edge. An in-flight transfer is dropped without response.
- No address decode beyond the mapped-region check.

Optional Feature:
- Macro: APB_ARB_PSLVERR_EN.
- Defined: a latched address with top two bits != 2'b00 skips ISSUE and goes directly IDLE->RESP. In RESP it drives pslverr=1, prdata=0 and leaves mem_enable low.
- Undefined: pslverrN tied 0 and every access is forwarded to the slave. Unmapped reads return the slave's 0; unmapped writes are ignored by the slave.

Test Plan:
- Req0 write 0xDEADBEEF, strb 4'hF, to 0x0040, then read 0x0040 -> mem_enable pulses 1 cycle with we=1; read returns prdata0=0xDEADBEEF; pready0 seen on cycle 3.
- Both psel asserted in the same cycle after reset -> req0 served first, then req1. Repeat with both -> req1 served first (round robin); grant_id toggles.
- Req1 write 0x11223344, strb 4'b0101, to 0x0100 after reg=0 -> readback 0x00220044.
- Req0 continuously requesting while req1 requests once -> req1 granted within one transfer of req0; never two consecutive req0 grants while req1 waits.
- rst asserted during ISSUE of a write -> next cycle busy=0, all pready=0, mem_enable=0; subsequent transfer completes normally.
- With APB_ARB_PSLVERR_EN defined, read 0x8000 -> pslverr0=1, prdata0=0, mem_enable never asserted. Undefined -> pslverr0=0, mem_enable pulses, prdata0=0.
